// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// ALU control codes and datapath select values.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    // Supported major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU control codes consumed by the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // FSM -> alu_decoder request: fixed add, fixed sub, or decode funct fields
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // result_src mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_a mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // alu_src_b mux
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: turns the FSM's coarse ALU request plus the IR funct fields
// into the 3-bit alu_control code.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Subtract only for R-type with funct7b5 set; addi ignores the immediate bit.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM of the multicycle RV32I core. One instruction step per state;
// drives every datapath select and write enable.
//
// Memory handshake: the FSM presents an access (fetch, load or store) and
// holds its outputs stable; mem_ready=1 in a cycle means the access completed
// in that cycle, and only then does the FSM advance. mem_ready is ignored in
// every state that does not own a memory access.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic [3:0] dbg_state
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_control;
    logic       w_reg_write;
    logic       w_illegal;

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (w_alu_control)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RD2;
        w_alu_op     = ALU_OP_ADD;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch/jump target into ALUOut
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_IMM;
                // opcode bit 5 separates store from load
                w_next      = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_RD2;
                w_alu_op    = ALU_OP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_IMM;
                w_alu_op    = ALU_OP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_FOUR;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BRANCH: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_RD2;
                w_alu_op    = ALU_OP_SUB;
                if (funct3[2:1] == 2'b00) begin
                    // beq takes on zero, bne on not-zero
                    w_pc_write = zero ^ funct3[0];
                end else begin
                    w_illegal = 1'b1;
                end
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Everything is held at zero while reset is asserted.
    assign pc_write      = rst_n & w_pc_write;
    assign adr_src       = rst_n & w_adr_src;
    assign mem_write     = rst_n & w_mem_write;
    assign ir_write      = rst_n & w_ir_write;
    assign reg_write     = rst_n & w_reg_write;
    assign illegal_instr = rst_n & w_illegal;
    assign result_src    = {2{rst_n}} & w_result_src;
    assign alu_src_a     = {2{rst_n}} & w_alu_src_a;
    assign alu_src_b     = {2{rst_n}} & w_alu_src_b;
    assign alu_control   = {3{rst_n}} & w_alu_control;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a table of instructions, each expanded into its
// per-cycle expected control word, plus hand-written stall and reset sequences.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int W = 19;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       illegal_instr;
    logic [3:0] dbg_state;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    typedef enum {K_R, K_I, K_LW, K_SW, K_JAL, K_BR, K_ILL} kind_t;
    typedef struct {
        string      name;
        kind_t      kind;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic [2:0] exp_alu;
        logic       exp_pcw;
        logic       exp_ill;
    } vec_t;
    vec_t vecs[$];

    // Clock
    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr),
        .dbg_state     (dbg_state)
    );

    // Field order: state, pc_write, adr_src, mem_write, ir_write, result_src,
    // alu_src_a, alu_src_b, alu_control, reg_write, illegal_instr
    function automatic logic [W-1:0] mk(input state_t st, input logic pcw, input logic adr,
                                        input logic mw, input logic irw, input logic [1:0] rs,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [2:0] alu, input logic rw, input logic ill);
        return {st, pcw, adr, mw, irw, rs, sa, sb, alu, rw, ill};
    endfunction

    function automatic logic [W-1:0] got_word();
        return {dbg_state, pc_write, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, alu_control, reg_write, illegal_instr};
    endfunction

    task automatic check(input string name, input logic [W-1:0] exp);
        logic [W-1:0] got;
        got = got_word();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%05h expected=%05h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive mem_ready, sample at negedge, return to posedge+1.
    task automatic cyc(input string name, input logic mr, input logic [W-1:0] exp);
        mem_ready = mr;
        exp_q.push_back(exp);
        @(negedge clk);
        check(name, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [W-1:0] w_fetch(input logic mr);
        return mk(S_FETCH, mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    endfunction

    function automatic logic [W-1:0] w_aluwb();
        return mk(S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    endfunction

    function automatic logic [W-1:0] w_memadr();
        return mk(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
    endfunction

    function automatic logic [W-1:0] w_memread();
        return mk(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    endfunction

    function automatic logic [W-1:0] w_memwb();
        return mk(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0);
    endfunction

    function automatic logic [W-1:0] w_memwrite();
        return mk(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    endfunction

    task automatic set_ir(input vec_t v);
        opcode   = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        zero     = v.zero;
    endtask

    // Runs one instruction from its fetch with no memory stalls; mem_ready is
    // randomised in states that must ignore it.
    task automatic run(input vec_t v);
        set_ir(v);
        cyc({v.name, "/fetch"}, 1'b1, w_fetch(1'b1));
        cyc({v.name, "/decode"}, rnd(),
            mk(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, v.kind == K_ILL));
        case (v.kind)
            K_R: begin
                cyc({v.name, "/execr"}, rnd(),
                    mk(S_EXECR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, v.exp_alu, 0, 0));
                cyc({v.name, "/aluwb"}, rnd(), w_aluwb());
            end
            K_I: begin
                cyc({v.name, "/execi"}, rnd(),
                    mk(S_EXECI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, v.exp_alu, 0, 0));
                cyc({v.name, "/aluwb"}, rnd(), w_aluwb());
            end
            K_LW: begin
                cyc({v.name, "/memadr"}, rnd(), w_memadr());
                cyc({v.name, "/memread"}, 1'b1, w_memread());
                cyc({v.name, "/memwb"}, rnd(), w_memwb());
            end
            K_SW: begin
                cyc({v.name, "/memadr"}, rnd(), w_memadr());
                cyc({v.name, "/memwrite"}, 1'b1, w_memwrite());
            end
            K_JAL: begin
                cyc({v.name, "/jal"}, rnd(),
                    mk(S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
                cyc({v.name, "/aluwb"}, rnd(), w_aluwb());
            end
            K_BR: begin
                cyc({v.name, "/branch"}, rnd(),
                    mk(S_BRANCH, v.exp_pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, v.exp_ill));
            end
            default: ;
        endcase
    endtask

    initial begin
        vec_t v;
        // name, kind, opcode, funct3, funct7b5, zero, exp alu_control, exp branch pc_write, exp illegal
        vecs.push_back('{"add",     K_R,   7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"sub",     K_R,   7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0});
        vecs.push_back('{"slt",     K_R,   7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0});
        vecs.push_back('{"or",      K_R,   7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0});
        vecs.push_back('{"and",     K_R,   7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0});
        vecs.push_back('{"r_f3_001",K_R,   7'b0110011, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"addi_b5", K_I,   7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"slti",    K_I,   7'b0010011, 3'b010, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0});
        vecs.push_back('{"andi",    K_I,   7'b0010011, 3'b111, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0});
        vecs.push_back('{"lw",      K_LW,  7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"sw",      K_SW,  7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"beq_z1",  K_BR,  7'b1100011, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0});
        vecs.push_back('{"beq_z0",  K_BR,  7'b1100011, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"bne_z1",  K_BR,  7'b1100011, 3'b001, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"bne_z0",  K_BR,  7'b1100011, 3'b001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0});
        vecs.push_back('{"blt_ill", K_BR,  7'b1100011, 3'b100, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1});
        vecs.push_back('{"jal",     K_JAL, 7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        vecs.push_back('{"ill_7f",  K_ILL, 7'b1111111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});

        // Reset: everything zero while rst_n is low, even with mem_ready high
        rst_n = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #12;
        check("reset_hold", mk(S_FETCH, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table sweep
        foreach (vecs[i]) run(vecs[i]);

        // Fetch stalls two cycles then completes
        cyc("fetch_stall0", 1'b0, w_fetch(1'b0));
        cyc("fetch_stall1", 1'b0, w_fetch(1'b0));
        run(vecs[0]);

        // lw with three wait cycles in S_MEMREAD
        v = vecs[9];
        set_ir(v);
        cyc("lws/fetch", 1'b1, w_fetch(1'b1));
        cyc("lws/decode", rnd(), mk(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0));
        cyc("lws/memadr", rnd(), w_memadr());
        for (int k = 0; k < 3; k++) cyc("lws/memread_wait", 1'b0, w_memread());
        cyc("lws/memread_done", 1'b1, w_memread());
        cyc("lws/memwb", rnd(), w_memwb());
        cyc("lws/next_fetch", 1'b0, w_fetch(1'b0));
        cyc("lws/next_fetch_go", 1'b1, w_fetch(1'b1));
        // Finish the instruction just fetched (still lw in the IR inputs)
        cyc("lws2/decode", rnd(), mk(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0));
        cyc("lws2/memadr", rnd(), w_memadr());
        cyc("lws2/memread", 1'b1, w_memread());
        cyc("lws2/memwb", rnd(), w_memwb());

        // Reset asserted in the middle of a stalled store
        v = vecs[10];
        set_ir(v);
        cyc("swr/fetch", 1'b1, w_fetch(1'b1));
        cyc("swr/decode", rnd(), mk(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0));
        cyc("swr/memadr", rnd(), w_memadr());
        cyc("swr/memwrite_wait", 1'b0, w_memwrite());
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("swr/reset_async", mk(S_FETCH, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("swr/post_reset_fetch", 1'b0, w_fetch(1'b0));
        run(vecs[1]);
        cyc("final_fetch", 1'b0, w_fetch(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
